// File: rtl/id_exe_pkg.sv
// id_exe_pkg: shared widths, field offsets and FSM states
// for the ID->EXE pipeline register.
package id_exe_pkg;
  localparam int ID_CTRL_W = 9;
  localparam int ID_DATA_W = 143;
  localparam int ID_CNT_W  = 16;

  localparam int EXE_CMD_LSB = 0;
  localparam int EXE_CMD_W   = 6;
  localparam int MEM_CMD_LSB = 6;
  localparam int MEM_CMD_W   = 2;
  localparam int WB_EN_BIT   = 8;

  localparam int REG_W    = 5;
  localparam int WORD_W   = 32;
  localparam int SRC2_LSB = 0;
  localparam int SRC1_LSB = 5;
  localparam int DST_LSB  = 10;
  localparam int REG2_LSB = 15;
  localparam int VAL2_LSB = 47;
  localparam int VAL1_LSB = 79;
  localparam int PC_LSB   = 111;

  localparam logic [ID_CTRL_W-1:0] CTRL_NOP = '0;

  typedef enum logic [1:0] {
    EMPTY,
    ONE,
    FULL
  } pipe_state_t;
endpackage

// File: rtl/id_exe_pipe_reg_if.sv
// id_exe_pipe_reg_if: ID-side and EXE-side valid/ready
// bundle of the ID->EXE pipeline register.
interface id_exe_pipe_reg_if #(
  parameter int CTRL_W = 9,
  parameter int DATA_W = 143
);
  logic              in_valid;
  logic              in_ready;
  logic [CTRL_W-1:0] in_ctrl;
  logic [DATA_W-1:0] in_data;
  logic              out_valid;
  logic              out_ready;
  logic [CTRL_W-1:0] out_ctrl;
  logic [DATA_W-1:0] out_data;

  modport master (
    output in_valid, in_ctrl, in_data, out_ready,
    input  in_ready, out_valid, out_ctrl, out_data
  );

  modport slave (
    input  in_valid, in_ctrl, in_data, out_ready,
    output in_ready, out_valid, out_ctrl, out_data
  );
endinterface

// File: rtl/pipe_skid_buf.sv
// pipe_skid_buf: single skid entry holding a beat that
// arrived while the output register was stalled.
module pipe_skid_buf #(
  parameter int W = 152
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         i_clr,
  input  logic         i_wr,
  input  logic [W-1:0] i_d,
  output logic [W-1:0] o_q
);
  logic [W-1:0] r_q;

  always_ff @(posedge clk) begin
    if (!rst || i_clr) begin
      r_q <= '0;
    end else if (i_wr) begin
      r_q <= i_d;
    end
  end

  assign o_q = r_q;
endmodule

// File: rtl/id_exe_pipe_reg.sv
// id_exe_pipe_reg: ID->EXE pipeline register with flush,
// saturating stall counter; ID_EXE_SKID_EN adds a skid entry.
module id_exe_pipe_reg
  import id_exe_pkg::*;
#(
  parameter int CTRL_W = ID_CTRL_W,
  parameter int DATA_W = ID_DATA_W,
  parameter int CNT_W  = ID_CNT_W
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             flush,
  id_exe_pipe_reg_if.slave bus,
  output logic [CNT_W-1:0] stall_cnt
);
  localparam int W = CTRL_W + DATA_W;

  logic              r_valid;
  logic [CTRL_W-1:0] r_ctrl;
  logic [DATA_W-1:0] r_data;
  logic [CNT_W-1:0]  r_cnt;

  logic         w_accept;
  logic         w_consume;
  logic         w_load_in;
  logic         w_load_skid;
  logic         w_drop;
  logic [W-1:0] w_nxt;

  assign w_accept  = bus.in_valid & bus.in_ready;
  assign w_consume = r_valid & bus.out_ready;

`ifdef ID_EXE_SKID_EN
  pipe_state_t  r_state;
  pipe_state_t  w_state_nxt;
  logic         r_rdy;
  logic         w_skid_wr;
  logic [W-1:0] w_skid_q;

  always_ff @(posedge clk) begin
    if (!rst || flush) begin
      r_state <= EMPTY;
      r_rdy   <= 1'b1;
    end else begin
      r_state <= w_state_nxt;
      r_rdy   <= (w_state_nxt != FULL);
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_load_in   = 1'b0;
    w_load_skid = 1'b0;
    w_drop      = 1'b0;
    w_skid_wr   = 1'b0;
    unique case (r_state)
      EMPTY: begin
        if (w_accept) begin
          w_state_nxt = ONE;
          w_load_in   = 1'b1;
        end
      end
      ONE: begin
        if (w_accept && w_consume) begin
          w_load_in = 1'b1;
        end else if (w_accept) begin
          w_state_nxt = FULL;
          w_skid_wr   = 1'b1;
        end else if (w_consume) begin
          w_state_nxt = EMPTY;
          w_drop      = 1'b1;
        end
      end
      FULL: begin
        if (w_consume) begin
          w_state_nxt = ONE;
          w_load_skid = 1'b1;
        end
      end
      default: w_state_nxt = EMPTY;
    endcase
  end

  pipe_skid_buf #(
    .W(W)
  ) u_skid (
    .clk  (clk),
    .rst  (rst),
    .i_clr(flush),
    .i_wr (w_skid_wr),
    .i_d  ({bus.in_ctrl, bus.in_data}),
    .o_q  (w_skid_q)
  );

  // ready is registered; rst only masks it while in reset
  assign bus.in_ready = rst & r_rdy;
  assign w_nxt = w_load_skid ? w_skid_q
                             : {bus.in_ctrl, bus.in_data};
`else
  assign w_load_in    = w_accept;
  assign w_load_skid  = 1'b0;
  assign w_drop       = w_consume & ~w_accept;
  assign bus.in_ready = rst & (~r_valid | bus.out_ready);
  assign w_nxt        = {bus.in_ctrl, bus.in_data};
`endif

  always_ff @(posedge clk) begin
    if (!rst) begin
      r_valid <= 1'b0;
      r_ctrl  <= CTRL_W'(CTRL_NOP);
      r_data  <= '0;
    end else if (flush) begin
      r_valid <= 1'b0;
      r_ctrl  <= CTRL_W'(CTRL_NOP);
    end else if (w_load_in || w_load_skid) begin
      r_valid          <= 1'b1;
      {r_ctrl, r_data} <= w_nxt;
    end else if (w_drop) begin
      r_valid <= 1'b0;
      r_ctrl  <= CTRL_W'(CTRL_NOP);
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      r_cnt <= '0;
    end else if (r_valid && !bus.out_ready && !(&r_cnt)) begin
      r_cnt <= r_cnt + 1'b1;
    end
  end

  assign bus.out_valid = r_valid;
  assign bus.out_ctrl  = r_ctrl;
  assign bus.out_data  = r_data;
  assign stall_cnt     = r_cnt;
endmodule

// File: tb/tb_id_exe_pipe_reg.sv
// tb_id_exe_pipe_reg: directed and random stimulus against a
// queue model of the ID->EXE register (either build).
module tb_id_exe_pipe_reg;
  localparam int CW   = 9;
  localparam int DW   = 143;
  localparam int NW   = 4;
  localparam int WW   = CW + DW;
  localparam int CMAX = (1 << NW) - 1;

  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic          flush = 1'b0;
  logic [NW-1:0] stall_cnt;

  id_exe_pipe_reg_if #(.CTRL_W(CW), .DATA_W(DW)) bus ();

  id_exe_pipe_reg #(
    .CTRL_W(CW),
    .DATA_W(DW),
    .CNT_W (NW)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .flush    (flush),
    .bus      (bus),
    .stall_cnt(stall_cnt)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  task automatic chk(input string name,
                     input logic [WW-1:0] got,
                     input logic [WW-1:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %h exp %h", name, got, exp);
    end
  endtask

  function automatic logic [DW-1:0] rnd_d();
    logic [159:0] t;
    t = {$urandom, $urandom, $urandom, $urandom, $urandom};
    return t[DW-1:0];
  endfunction

  // reference: queue of beats accepted and not yet consumed
  logic [WW-1:0] q[$];
  int            cnt_m = 0;
  logic          m_rdy;

  always @(negedge clk) begin
    if (!rst) m_rdy = 1'b0;
`ifdef ID_EXE_SKID_EN
    else m_rdy = (q.size() < 2);
`else
    else m_rdy = (q.size() == 0) || bus.out_ready;
`endif
    chk("in_ready", WW'(bus.in_ready), WW'(m_rdy));
    if (q.size() > 0) begin
      chk("out_valid", WW'(bus.out_valid), WW'(1'b1));
      chk("out_beat", {bus.out_ctrl, bus.out_data}, q[0]);
    end else begin
      chk("idle_valid", WW'(bus.out_valid), WW'(1'b0));
      chk("idle_ctrl", WW'(bus.out_ctrl), WW'(0));
    end
    chk("stall_cnt", WW'(stall_cnt), WW'(cnt_m));
    if (!rst) begin
      q.delete();
      cnt_m = 0;
    end else begin
      if (q.size() > 0 && !bus.out_ready && cnt_m < CMAX)
        cnt_m++;
      if (q.size() > 0 && bus.out_ready)
        void'(q.pop_front());
      if (flush)
        q.delete();
      else if (bus.in_valid && m_rdy)
        q.push_back({bus.in_ctrl, bus.in_data});
    end
  end

  task automatic drive(input logic r, input logic v,
                       input logic [CW-1:0] c,
                       input logic [DW-1:0] d,
                       input logic f, input logic ordy);
    @(posedge clk);
    #1;
    rst           = r;
    bus.in_valid  = v;
    bus.in_ctrl   = c;
    bus.in_data   = d;
    flush         = f;
    bus.out_ready = ordy;
  endtask

  logic acc;
  logic hold;

  initial begin
    bus.in_valid  = 1'b1;
    bus.in_ctrl   = 9'h1FF;
    bus.in_data   = rnd_d();
    bus.out_ready = 1'b1;

    // reset with in_valid asserted
    repeat (3) drive(0, 1, 9'($urandom), rnd_d(), 0, 1);
    drive(1, 0, '0, '0, 0, 1);
    @(negedge clk);
    chk("rst_ready", WW'(bus.in_ready), WW'(1'b1));
    chk("rst_valid", WW'(bus.out_valid), WW'(1'b0));
    chk("rst_cnt", WW'(stall_cnt), WW'(0));

    // streaming
    for (int i = 0; i < 8; i++)
      drive(1, 1, 9'h1A5, DW'(i), 0, 1);
    repeat (2) drive(1, 0, '0, '0, 0, 1);

    // stall with held beat, second beat into skid
    drive(0, 0, '0, '0, 0, 1);
    drive(1, 1, 9'h0F3, DW'(8'h55), 0, 0);
    drive(1, 1, 9'h0C7, DW'(8'h66), 0, 0);
    repeat (5) drive(1, 0, '0, '0, 0, 0);
    @(negedge clk);
    chk("stall_cnt5", WW'(stall_cnt), WW'(5));
    chk("stall_data", WW'(bus.out_data), WW'(8'h55));
    repeat (3) drive(1, 0, '0, '0, 0, 1);

    // flush while stalled and full
    drive(1, 1, 9'h011, DW'(8'hA1), 0, 0);
    drive(1, 1, 9'h022, DW'(8'hA2), 0, 0);
    drive(1, 1, 9'h033, DW'(8'hA3), 1, 0);
    drive(1, 0, '0, '0, 0, 1);
    @(negedge clk);
    chk("flush_valid", WW'(bus.out_valid), WW'(1'b0));
    chk("flush_ctrl", WW'(bus.out_ctrl), WW'(0));
    chk("flush_ready", WW'(bus.in_ready), WW'(1'b1));
    repeat (3) drive(1, 0, '0, '0, 0, 1);

    // counter saturation
    drive(0, 0, '0, '0, 0, 1);
    drive(1, 1, 9'h1A5, DW'(8'h77), 0, 0);
    repeat (20) drive(1, 0, '0, '0, 0, 0);
    @(negedge clk);
    chk("sat_cnt", WW'(stall_cnt), WW'(CMAX));
    repeat (2) drive(1, 0, '0, '0, 0, 1);

    // random traffic, data held stable while not accepted
    for (int n = 0; n < 10000; n++) begin
      @(negedge clk);
      acc  = bus.in_valid && bus.in_ready;
      hold = rst && bus.in_valid && !acc && !flush;
      @(posedge clk);
      #1;
      rst           = ($urandom_range(0, 499) != 0);
      flush         = ($urandom_range(0, 31) == 0);
      bus.out_ready = ($urandom_range(0, 9) < 7);
      if (!hold) begin
        bus.in_valid = ($urandom_range(0, 3) != 0);
        bus.in_ctrl  = 9'($urandom);
        bus.in_data  = rnd_d();
      end
    end
    repeat (4) drive(1, 0, '0, '0, 0, 1);
    @(negedge clk);
    #1;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
